// File: rtl/rca4_seq_ctrl.sv
// Nibble-serial W-bit adder: one shared 4-bit ripple-carry adder is stepped
// LSB nibble first, with a registered carry chaining the slices.

module P2_RCA4_hier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

// state | meaning
// IDLE  | waiting for start; last result held on sum/co/ovf
// RUN   | one nibble added per clock, idx selects the slice
// DONE  | one-cycle done pulse, back to IDLE unconditionally
module rca4_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 ci,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 co,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_r, b_r;
  logic            carry_r;
  logic [IW-1:0]   idx;
  logic [3:0]      nib_a, nib_b, rca_s;
  logic            rca_co;
  logic            last;

  assign last = (idx == IW'(NIBBLES - 1));

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IW'(k)) begin
        nib_a = a_r[4*k +: 4];
        nib_b = b_r[4*k +: 4];
      end
    end
  end

  P2_RCA4_hier u_rca (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_r),
    .s  (rca_s),
    .co (rca_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= ci;
            idx     <= '0;
            sum     <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (idx == IW'(k)) sum[4*k +: 4] <= rca_s;
          end
          carry_r <= rca_co;
          idx     <= idx + 1'b1;
          // Signed overflow: operands agree in sign but the top nibble's MSB differs.
          if (last) begin
            co  <= rca_co;
            ovf <= (a_r[W-1] == b_r[W-1]) && (rca_s[3] != a_r[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule
